// File: rtl/fir_drive_ctrl.sv
// Sample-side controller for one FIR band: holds a sample, pulses the filter, returns its result.
// Optional watchdog on the result wait is enabled by defining FIR_DRIVE_TIMEOUT_EN.
module fir_drive_ctrl #(
  parameter int SETTLE  = 1,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk_fast,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [9:0]       in_data,
  output logic             in_ready,
  input  logic             clr_req,
  output logic [9:0]       fir_in,
  output logic             fir_en,
  output logic             fir_clr,
  input  logic [9:0]       fir_out,
  input  logic             fir_out_avl,
  output logic             out_valid,
  output logic [9:0]       out_data,
  input  logic             out_ready,
  output logic             timeout_err,
  output logic [CNT_W-1:0] sample_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_AVL, OUT, CLEAR} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_settleCnt;
  logic             r_avlQ;
  logic [9:0]       r_firIn;
  logic             r_outValid;
  logic [9:0]       r_outData;
  logic [CNT_W-1:0] r_sampleCnt;
  logic             w_rise;
  logic             w_expire;

  // Only a fresh rising edge of the filter's level flag completes a sample.
  assign w_rise = fir_out_avl && !r_avlQ;

`ifdef FIR_DRIVE_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [15:0] r_wdCnt;
  logic        r_timeoutErr;

  assign w_expire    = (r_wdCnt == WD_LAST);
  assign timeout_err = r_timeoutErr;

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      r_wdCnt      <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      if (r_state == START)
        r_wdCnt <= '0;
      else if (r_state == WAIT_AVL && !w_rise)
        r_wdCnt <= r_wdCnt + 16'd1;
      if (r_state == WAIT_AVL && !w_rise && w_expire)
        r_timeoutErr <= 1'b1;
      else if (r_state == CLEAR)
        r_timeoutErr <= 1'b0;
    end
  end
`else
  assign w_expire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk_fast) begin
    if (rst) r_state <= CLEAR;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (clr_req)       w_next = CLEAR;
        else if (in_valid) w_next = LOAD;
      end
      LOAD:     if (r_settleCnt == SETTLE_LAST) w_next = START;
      START:    w_next = WAIT_AVL;
      WAIT_AVL: if (w_rise || w_expire) w_next = OUT;
      OUT:      if (out_ready) w_next = IDLE;
      CLEAR:    w_next = IDLE;
      default:  w_next = CLEAR;
    endcase
  end

  // fir_en is masked by reset so it can never coincide with fir_clr.
  always_comb begin
    in_ready = (r_state == IDLE) && !clr_req;
    fir_en   = (r_state == START) && !rst;
    fir_clr  = rst || (r_state == CLEAR);
  end

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      r_settleCnt <= '0;
      r_avlQ      <= 1'b0;
      r_firIn     <= '0;
      r_outValid  <= 1'b0;
      r_outData   <= '0;
      r_sampleCnt <= '0;
    end else begin
      r_avlQ <= (r_state == CLEAR) ? 1'b0 : fir_out_avl;
      case (r_state)
        IDLE: begin
          if (!clr_req && in_valid) begin
            r_firIn     <= in_data;
            r_settleCnt <= '0;
          end
        end
        LOAD: r_settleCnt <= r_settleCnt + 4'd1;
        WAIT_AVL: begin
          if (w_rise) begin
            r_outData  <= fir_out;
            r_outValid <= 1'b1;
          end else if (w_expire) begin
            r_outData  <= '0;
            r_outValid <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            r_outValid  <= 1'b0;
            r_sampleCnt <= r_sampleCnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign fir_in     = r_firIn;
  assign out_valid  = r_outValid;
  assign out_data   = r_outData;
  assign sample_cnt = r_sampleCnt;

endmodule

// File: tb/tb_fir_drive_ctrl.sv
// Scoreboard bench for fir_drive_ctrl: random samples, a behavioural filter model and a result queue.
// Define FIR_DRIVE_TIMEOUT_EN for both files to also exercise the watchdog path.
module tb_fir_drive_ctrl;

  localparam int SETTLE  = 1;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic             clk_fast = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [9:0]       in_data;
  logic             in_ready;
  logic             clr_req;
  logic [9:0]       fir_in;
  logic             fir_en;
  logic             fir_clr;
  logic [9:0]       fir_out;
  logic             fir_out_avl;
  logic             out_valid;
  logic [9:0]       out_data;
  logic             out_ready;
  logic             timeout_err;
  logic [CNT_W-1:0] sample_cnt;

  int         nChecks = 0;
  int         nFail   = 0;
  int         expCnt  = 0;
  bit         expErr  = 1'b0;
  logic [9:0] expQ[$];

  fir_drive_ctrl #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_fast(clk_fast), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .clr_req(clr_req), .fir_in(fir_in), .fir_en(fir_en),
    .fir_clr(fir_clr), .fir_out(fir_out), .fir_out_avl(fir_out_avl),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .timeout_err(timeout_err), .sample_cnt(sample_cnt)
  );

  always #5 clk_fast = ~clk_fast;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_fast);
    #1;
  endtask

  // Result monitor: every downstream handshake must match the oldest expected result.
  always @(negedge clk_fast) begin
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFail++;
        $display("[TB] FAIL unexpected_output: got 0x%0h, expected no output", out_data);
      end else begin
        checkOutput("out_data_handshake", 32'(out_data), 32'(expQ.pop_front()));
      end
    end
  end

  always @(negedge clk_fast) begin
    if (fir_clr) checkOutput("en_vs_clr", 32'(fir_en), 32'd0);
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  // One whole transaction; 'lat' is the filter latency, or the stuck-high hold time when avl is already high.
  task automatic applyStimulus(input logic [9:0] data, input logic [9:0] result, input int lat,
                               input int stall, input bit withClr, input bit timeoutCase);
    logic [9:0] expData;
    if (withClr) begin
      clr_req = 1'b1; in_valid = 1'b1; in_data = data;
      @(negedge clk_fast);
      checkOutput("clr_in_ready", 32'(in_ready), 32'd0);
      checkOutput("clr_fir_clr_pre", 32'(fir_clr), 32'd0);
      checkOutput("err_sticky", 32'(timeout_err), 32'(expErr));
      tick();
      clr_req = 1'b0;
      @(negedge clk_fast);
      checkOutput("clr_fir_clr", 32'(fir_clr), 32'd1);
      checkOutput("clr_in_ready_busy", 32'(in_ready), 32'd0);
      tick();
      expErr = 1'b0;
      @(negedge clk_fast);
      checkOutput("clr_fir_clr_done", 32'(fir_clr), 32'd0);
      checkOutput("clr_keeps_cnt", 32'(sample_cnt), 32'(expCnt % (1 << CNT_W)));
      checkOutput("clr_err", 32'(timeout_err), 32'd0);
    end else begin
      in_valid = 1'b1; in_data = data;
      @(negedge clk_fast);
    end
    checkOutput("in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 10'($urandom);
    for (int k = 1; k <= SETTLE + 1; k++) begin
      @(negedge clk_fast);
      checkOutput("fir_en", 32'(fir_en), 32'(k == SETTLE + 1));
      checkOutput("fir_in_hold", 32'(fir_in), 32'(data));
      if (k <= SETTLE) tick();
    end
    tick();
    if (timeoutCase) begin
      expData = '0;
      expQ.push_back(expData);
      for (int k = 0; k <= TIMEOUT; k++) begin
        @(negedge clk_fast);
        checkOutput("timeout_valid", 32'(out_valid), 32'(k == TIMEOUT));
        if (k < TIMEOUT) tick();
      end
      expErr = 1'b1;
      checkOutput("timeout_err_set", 32'(timeout_err), 32'd1);
      checkOutput("timeout_data", 32'(out_data), 32'd0);
    end else begin
      expData = result;
      if (fir_out_avl) begin
        fir_out = 10'($urandom);
        for (int s = 0; s < lat; s++) begin
          @(negedge clk_fast);
          checkOutput("stuck_no_done", 32'(out_valid), 32'd0);
          tick();
        end
        fir_out_avl = 1'b0;
        @(negedge clk_fast);
        checkOutput("stuck_low_no_done", 32'(out_valid), 32'd0);
        tick();
      end else begin
        for (int s = 0; s < lat; s++) begin
          @(negedge clk_fast);
          checkOutput("wait_no_done", 32'(out_valid), 32'd0);
          tick();
        end
      end
      fir_out = result;
      fir_out_avl = 1'b1;
      expQ.push_back(expData);
      @(negedge clk_fast);
      checkOutput("rise_cycle_valid", 32'(out_valid), 32'd0);
      tick();
      @(negedge clk_fast);
      checkOutput("rise_next_valid", 32'(out_valid), 32'd1);
      checkOutput("no_timeout_err", 32'(timeout_err), 32'(expErr));
    end
    for (int s = 0; s < stall; s++) begin
      tick();
      out_ready = 1'b0;
      clr_req   = 1'($urandom_range(0, 1));
      @(negedge clk_fast);
      checkOutput("stall_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_data", 32'(out_data), 32'(expData));
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_no_clr", 32'(fir_clr), 32'd0);
    end
    tick();
    clr_req = 1'b0;
    out_ready = 1'b1;
    if ($urandom_range(0, 1) == 1) fir_out_avl = 1'b0;
    @(negedge clk_fast);
    tick();
    out_ready = 1'b0;
    expCnt++;
    @(negedge clk_fast);
    checkOutput("post_valid", 32'(out_valid), 32'd0);
    checkOutput("sample_cnt", 32'(sample_cnt), 32'(expCnt % (1 << CNT_W)));
    checkOutput("post_in_ready", 32'(in_ready), 32'd1);
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; clr_req = 1'b0;
    fir_out = '0; fir_out_avl = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk_fast);
    checkOutput("rst_fir_clr", 32'(fir_clr), 32'd1);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_fir_en", 32'(fir_en), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_fir_in", 32'(fir_in), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("rst_sample_cnt", 32'(sample_cnt), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk_fast);
    checkOutput("clear_cycle_fir_clr", 32'(fir_clr), 32'd1);
    checkOutput("clear_cycle_in_ready", 32'(in_ready), 32'd0);
    tick();
    @(negedge clk_fast);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_fir_clr", 32'(fir_clr), 32'd0);
    tick();

    fir_out_avl = 1'b0;
    applyStimulus(10'h1C5, 10'h2A3, 2, 5, 1'b0, 1'b0);
    fir_out_avl = 1'b1;
    applyStimulus(10'($urandom), 10'($urandom), 2, 1, 1'b0, 1'b0);
    applyStimulus(10'($urandom), 10'($urandom), 1, 0, 1'b1, 1'b0);
    fir_out_avl = 1'b0;
    applyStimulus(10'($urandom), 10'($urandom), TIMEOUT - 1, 2, 1'b0, 1'b0);
`ifdef FIR_DRIVE_TIMEOUT_EN
    fir_out_avl = 1'b0;
    applyStimulus(10'($urandom), 10'($urandom), 0, 2, 1'b0, 1'b1);
    applyStimulus(10'($urandom), 10'($urandom), 1, 0, 1'b1, 1'b0);
`endif
    for (int i = 0; i < 20; i++) begin
      bit stuck;
      stuck = 1'($urandom_range(0, 1));
      fir_out_avl = stuck;
      applyStimulus(10'($urandom), 10'($urandom),
                    stuck ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), 1'b0);
    end

    // Reset during WAIT_AVL abandons the sample entirely.
    fir_out_avl = 1'b0;
    in_valid = 1'b1; in_data = 10'($urandom);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    expCnt = 0;
    expErr = 1'b0;
    fir_out = 10'($urandom);
    fir_out_avl = 1'b1;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk_fast);
      checkOutput("abandon_no_valid", 32'(out_valid), 32'd0);
      tick();
    end
    @(negedge clk_fast);
    checkOutput("abandon_cnt", 32'(sample_cnt), 32'd0);
    checkOutput("abandon_queue_empty", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
